// File: rtl/pmod_pkg.sv
// rtl/pmod_pkg.sv - shared types and helpers for the 7-segment display scheduler
package pmod_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } sched_state_e;

    // One-hot of a requester index; callers truncate to their own NUM_REQ.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/pmod_rr_arbiter.sv
// rtl/pmod_rr_arbiter.sv - combinational round-robin picker starting after ptr
module pmod_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic               found,
    output logic [IDXW-1:0]    idx
);

    // Scan ptr+1, ptr+2, ... wrapping modulo NUM_REQ; first asserted request wins.
    always_comb begin
        logic [IDXW:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDXW+1)'(k);
            if (cand >= (IDXW+1)'(NUM_REQ)) begin
                cand = cand - (IDXW+1)'(NUM_REQ);
            end
            if (!found && req[cand[IDXW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/pmod_7seg_sched.sv
// rtl/pmod_7seg_sched.sv - round-robin time-sliced sharing of the two-digit display
module pmod_7seg_sched
    import pmod_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  TICK_CYCLES = 100000,
    parameter int  HOLD_TICKS  = 1000,
    localparam int IDXW        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [3:0]           numa,
    output logic [3:0]           numb,
    output logic [IDXW-1:0]      owner,
    output logic                 disp_valid
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int TW = $clog2(HOLD_TICKS + 1);

    if (HOLD_TICKS < 1) begin : g_bad_hold
        $error("pmod_7seg_sched: HOLD_TICKS must be at least 1");
    end
    if (TICK_CYCLES < 1) begin : g_bad_tick
        $error("pmod_7seg_sched: TICK_CYCLES must be at least 1");
    end
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_req
        $error("pmod_7seg_sched: NUM_REQ must be in 2..16");
    end

    sched_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [3:0]           numa_q, numa_d;
    logic [3:0]           numb_q, numb_d;
    logic [IDXW-1:0]      owner_q, owner_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic                 valid_q, valid_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [TW-1:0]        tick_q, tick_d;

    logic                 win_found;
    logic [IDXW-1:0]      win_idx;
    logic [7:0]           win_data;
    logic                 capture;

    pmod_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .found (win_found),
        .idx   (win_idx)
    );

    assign win_data = req_data[8*int'(win_idx) +: 8];

    // Next-state: FSM, hold timing, and capture of the winner into the display registers.
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        numa_d  = numa_q;
        numb_d  = numb_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                capture = win_found;
            end
            GRANT: begin
                presc_d = '0;
                tick_d  = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (presc_q == PW'(TICK_CYCLES - 1)) begin
                    presc_d = '0;
                    tick_d  = tick_q + TW'(1);
                    // Last tick of the slice: hand over or release the display.
                    if (tick_q == TW'(HOLD_TICKS - 1)) begin
                        if (win_found) begin
                            capture = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            numa_d  = win_data[7:4];
            numb_d  = win_data[3:0];
            owner_d = win_idx;
            ptr_d   = win_idx;
            gnt_d   = NUM_REQ'(onehot(4'(win_idx)));
            valid_d = 1'b1;
            state_d = GRANT;
        end
    end

    // State and output registers; reset points the pointer at the last slot so slot 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            numa_q  <= '0;
            numb_q  <= '0;
            owner_q <= '0;
            ptr_q   <= IDXW'(NUM_REQ - 1);
            valid_q <= 1'b0;
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            numa_q  <= numa_d;
            numb_q  <= numb_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign gnt        = gnt_q;
    assign numa       = numa_q;
    assign numb       = numb_q;
    assign owner      = owner_q;
    assign disp_valid = valid_q;

endmodule

// File: tb/tb_pmod_7seg_sched.sv
// tb/tb_pmod_7seg_sched.sv - self-checking bench for pmod_7seg_sched
module tb_pmod_7seg_sched;

    localparam int NR  = 4;
    localparam int TC  = 4;
    localparam int HT  = 2;
    localparam int PER = 1 + HT * TC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NR-1:0]   req;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   gnt;
    logic [3:0]      numa, numb;
    logic [1:0]      owner;
    logic            disp_valid;

    pmod_7seg_sched #(.NUM_REQ(NR), .TICK_CYCLES(TC), .HOLD_TICKS(HT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .numa(numa), .numb(numb), .owner(owner), .disp_valid(disp_valid)
    );

    logic        rst3_n;
    logic [2:0]  req3;
    logic [23:0] data3;
    logic [2:0]  gnt3;
    logic [3:0]  numa3, numb3;
    logic [1:0]  owner3;
    logic        valid3;

    pmod_7seg_sched #(.NUM_REQ(3), .TICK_CYCLES(TC), .HOLD_TICKS(HT)) dut3 (
        .clk(clk), .rst_n(rst3_n), .req(req3), .req_data(data3),
        .gnt(gnt3), .numa(numa3), .numb(numb3), .owner(owner3), .disp_valid(valid3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] o, input logic v);
        chk({tag, ".gnt"},   32'(gnt),        32'(g));
        chk({tag, ".numa"},  32'(numa),       32'(a));
        chk({tag, ".numb"},  32'(numb),       32'(b));
        chk({tag, ".owner"}, 32'(owner),      32'(o));
        chk({tag, ".valid"}, 32'(disp_valid), 32'(v));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          wait_cyc;
        logic [3:0]  gnt;
        logic [3:0]  numa;
        logic [3:0]  numb;
        logic [1:0]  owner;
        logic        valid;
    } vec_t;

    vec_t tbl[6];

    // Reference model state: cycles left in the current slice and the rotation pointer.
    int         m_rem, m_ptr, m_win;
    logic [3:0] m_gnt, m_a, m_b;
    logic [1:0] m_own;
    logic       m_val;

    initial begin
        tbl[0] = '{4'b1111, 32'h33221100, 1,   4'b0001, 4'h0, 4'h0, 2'd0, 1'b1};
        tbl[1] = '{4'b1111, 32'h33221100, 1,   4'b0000, 4'h0, 4'h0, 2'd0, 1'b1};
        tbl[2] = '{4'b1111, 32'h33221100, 8,   4'b0010, 4'h1, 4'h1, 2'd1, 1'b1};
        tbl[3] = '{4'b1111, 32'h33221100, PER, 4'b0100, 4'h2, 4'h2, 2'd2, 1'b1};
        tbl[4] = '{4'b1111, 32'h33221100, PER, 4'b1000, 4'h3, 4'h3, 2'd3, 1'b1};
        tbl[5] = '{4'b1111, 32'h33221100, PER, 4'b0001, 4'h0, 4'h0, 2'd0, 1'b1};

        rst_n = 1'b0; req = '0; req_data = '0;
        rst3_n = 1'b0; req3 = '0; data3 = '0;
        step(2);
        chk_out("reset", 4'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        rst_n = 1'b1; rst3_n = 1'b1;
        step(1);
        chk_out("idle_noreq", 4'b0, 4'h0, 4'h0, 2'd0, 1'b0);

        // Single request: latency of one cycle, slice of PER cycles.
        req = 4'b0100; req_data = 32'h003C0000;
        step(1);
        chk_out("single", 4'b0100, 4'h3, 4'hC, 2'd2, 1'b1);
        req = '0;
        step(PER - 1);
        chk("single_last_hold.valid", 32'(disp_valid), 32'd1);
        chk("single_last_hold.gnt", 32'(gnt), 32'd0);
        step(1);
        chk_out("single_end", 4'b0, 4'h3, 4'hC, 2'd2, 1'b0);

        // Round robin from a fresh reset.
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].req; req_data = tbl[i].data;
            step(tbl[i].wait_cyc);
            chk_out($sformatf("rr%0d", i), tbl[i].gnt, tbl[i].numa, tbl[i].numb,
                    tbl[i].owner, tbl[i].valid);
        end

        // No preemption: requester 3 arrives while requester 1 holds.
        req = 4'b0010;
        step(PER);
        chk_out("nopre_own1", 4'b0010, 4'h1, 4'h1, 2'd1, 1'b1);
        req = '0;
        step(4);
        req = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk($sformatf("nopre_wait%0d.gnt", k), 32'(gnt), 32'd0);
        end
        step(1);
        chk_out("nopre_gnt3", 4'b1000, 4'h3, 4'h3, 2'd3, 1'b1);
        req = '0;

        // One-cycle request pulse during another owner's slice is lost.
        step(3);
        req = 4'b0001;
        step(1);
        req = '0;
        step(PER - 4);
        chk_out("dropped_end", 4'b0, 4'h3, 4'h3, 2'd3, 1'b0);
        step(3);
        chk_out("dropped_idle", 4'b0, 4'h3, 4'h3, 2'd3, 1'b0);

        // Asynchronous reset in the middle of a slice.
        req = 4'b0100; req_data = 32'h332211A5;
        step(1);
        chk_out("mid_gnt2", 4'b0100, 4'h2, 4'h2, 2'd2, 1'b1);
        req = '0;
        step(3);
        #2 rst_n = 1'b0;
        #1 chk_out("mid_rst", 4'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk_out("after_rst", 4'b0001, 4'hA, 4'h5, 2'd0, 1'b1);
        req = '0;
        step(PER + 1);

        // Three requesters: rotation wraps at 3, never index 3.
        req3 = 3'b111; data3 = 24'h221100;
        begin
            int gi;
            gi = 0;
            for (int cyc = 1; cyc <= 3 * PER + 1; cyc++) begin
                step(1);
                chk("nr3_owner_range", 32'(owner3 < 2'd3), 32'd1);
                if (cyc % PER == 1) begin
                    chk($sformatf("nr3_gnt%0d", gi), 32'(gnt3), 32'(1 << (gi % 3)));
                    chk($sformatf("nr3_numa%0d", gi), 32'(numa3), 32'(gi % 3));
                    gi++;
                end else begin
                    chk("nr3_gnt_quiet", 32'(gnt3), 32'd0);
                end
            end
        end
        req3 = '0;

        // Randomized traffic against a slice-level reference model.
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        m_rem = 0; m_ptr = NR - 1; m_gnt = '0; m_a = '0; m_b = '0; m_own = '0; m_val = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk_out("rand", m_gnt, m_a, m_b, m_own, m_val);
            req      = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            req_data = $urandom;
            m_gnt = '0;
            if (m_rem > 0) m_rem--;
            if (m_rem == 0) begin
                if (req != '0) begin
                    m_win = 0;
                    for (int k = 1; k <= NR; k++) begin
                        if (req[(m_ptr + k) % NR]) begin
                            m_win = (m_ptr + k) % NR;
                            break;
                        end
                    end
                    m_gnt = 4'(1 << m_win);
                    m_a   = req_data[8*m_win+4 +: 4];
                    m_b   = req_data[8*m_win +: 4];
                    m_own = 2'(m_win);
                    m_ptr = m_win;
                    m_val = 1'b1;
                    m_rem = PER;
                end else begin
                    m_val = 1'b0;
                end
            end
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
